// File: rtl/or_gate_sync.sv
// Two-input bitwise OR with a combinational output, a registered copy and a rising-edge pulse.
// Define OR_GATE_STATS_EN to compile in the saturating hi_cnt/rise_cnt activity counters.
module or_gate_sync #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q,
  output logic             z_rise,
  input  logic             clr
`ifdef OR_GATE_STATS_EN
  ,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] rise_cnt
`endif
);

  logic [WIDTH-1:0] z_d;
  logic             any_d;
  logic             rise_d;

  // Next-state for the registered copy and the 0->1 detector on the reduced value
  always_comb begin
    z_d    = x | y;
    any_d  = |z_d;
    rise_d = any_d & ~(|z_q);
  end

  assign z = z_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q    <= '0;
      z_rise <= 1'b0;
    end else begin
      z_q    <= z_d;
      z_rise <= rise_d;
    end
  end

`ifdef OR_GATE_STATS_EN
  localparam int unsigned CW1 = CNT_W + 1;

  logic [CNT_W:0]   hi_sum;
  logic [CNT_W:0]   rise_sum;
  logic [CNT_W-1:0] hi_d;
  logic [CNT_W-1:0] rise_cnt_d;

  // Increment one bit wide, clamp on carry-out; clr overrides any increment
  always_comb begin
    hi_sum     = {1'b0, hi_cnt} + CW1'(any_d);
    rise_sum   = {1'b0, rise_cnt} + CW1'(rise_d);
    hi_d       = hi_sum[CNT_W] ? '1 : hi_sum[CNT_W-1:0];
    rise_cnt_d = rise_sum[CNT_W] ? '1 : rise_sum[CNT_W-1:0];
    if (clr) begin
      hi_d       = '0;
      rise_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt   <= '0;
      rise_cnt <= '0;
    end else begin
      hi_cnt   <= hi_d;
      rise_cnt <= rise_cnt_d;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
`endif

endmodule

// File: tb/tb_or_gate_sync.sv
// Bench for or_gate_sync: a WIDTH=1/CNT_W=4 and a WIDTH=4/CNT_W=16 instance against a history-based model.
module tb_or_gate_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [0:0] x1, y1, z1, zq1;
  logic       zr1;
  logic [3:0] x4, y4, z4, zq4;
  logic       zr4;
`ifdef OR_GATE_STATS_EN
  logic [3:0]  hi1, rc1;
  logic [15:0] hi4, rc4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  or_gate_sync #(.WIDTH(1), .CNT_W(4)) u_w1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .z(z1), .z_q(zq1), .z_rise(zr1), .clr(clr)
`ifdef OR_GATE_STATS_EN
    , .hi_cnt(hi1), .rise_cnt(rc1)
`endif
  );

  or_gate_sync #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .z(z4), .z_q(zq4), .z_rise(zr4), .clr(clr)
`ifdef OR_GATE_STATS_EN
    , .hi_cnt(hi4), .rise_cnt(rc4)
`endif
  );

  // Model: remembers the last sampled OR value and counts events as plain integers
  int m_last[2];
  int m_rise[2];
  int m_hi[2];
  int m_rc[2];
  int m_max[2] = '{15, 65535};

  always @(posedge clk or negedge rst_n) begin
    int s[2];
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_last[i] = 0; m_rise[i] = 0; m_hi[i] = 0; m_rc[i] = 0;
      end
    end else begin
      s[0] = int'(x1) | int'(y1);
      s[1] = int'(x4) | int'(y4);
      for (int i = 0; i < 2; i++) begin
        m_rise[i] = (s[i] != 0 && m_last[i] == 0) ? 1 : 0;
        m_last[i] = s[i];
        if (clr) begin
          m_hi[i] = 0;
          m_rc[i] = 0;
        end else begin
          if (s[i] != 0) m_hi[i] = (m_hi[i] + 1 > m_max[i]) ? m_max[i] : m_hi[i] + 1;
          if (m_rise[i] != 0) m_rc[i] = (m_rc[i] + 1 > m_max[i]) ? m_max[i] : m_rc[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("w1_z",    int'(z1),  int'(x1) | int'(y1));
    chk("w1_z_q",  int'(zq1), m_last[0]);
    chk("w1_rise", int'(zr1), m_rise[0]);
    chk("w4_z",    int'(z4),  int'(x4) | int'(y4));
    chk("w4_z_q",  int'(zq4), m_last[1]);
    chk("w4_rise", int'(zr4), m_rise[1]);
`ifdef OR_GATE_STATS_EN
    chk("w1_hi_cnt",   int'(hi1), m_hi[0]);
    chk("w1_rise_cnt", int'(rc1), m_rc[0]);
    chk("w4_hi_cnt",   int'(hi4), m_hi[1]);
    chk("w4_rise_cnt", int'(rc4), m_rc[1]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    logic [3:0] xv;
    logic [3:0] yv;
    logic [3:0] zv;
  } vec_t;

  initial begin
    vec_t v1[5];
    vec_t v4[4];
    int   rise_seen;

    v1[0] = '{4'd0, 4'd0, 4'd0};
    v1[1] = '{4'd1, 4'd0, 4'd1};
    v1[2] = '{4'd1, 4'd1, 4'd1};
    v1[3] = '{4'd1, 4'd0, 4'd1};
    v1[4] = '{4'd1, 4'd1, 4'd1};
    v4[0] = '{4'b0101, 4'b0011, 4'b0111};
    v4[1] = '{4'b0000, 4'b0000, 4'b0000};
    v4[2] = '{4'b1000, 4'b0001, 4'b1001};
    v4[3] = '{4'b1010, 4'b0101, 4'b1111};

    rst_n = 1'b0; clr = 1'b0;
    x1 = '0; y1 = '0; x4 = '0; y4 = '0;
    #5;
    chk("rst_w1_z_q", int'(zq1), 0);
    chk("rst_w1_rise", int'(zr1), 0);
    chk("rst_w4_z_q", int'(zq4), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: combinational z immediately, z_q one edge later
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      x1 = v1[i].xv[0:0]; y1 = v1[i].yv[0:0];
      #1;
      chk("tbl_w1_z", int'(z1), int'(v1[i].zv));
      tick();
      chk("tbl_w1_z_q", int'(zq1), int'(v1[i].zv));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x4 = v4[i].xv; y4 = v4[i].yv;
      #1;
      chk("tbl_w4_z", int'(z4), int'(v4[i].zv));
      tick();
      chk("tbl_w4_z_q", int'(zq4), int'(v4[i].zv));
    end

    // Edge: clear, 3 idle cycles, then 5 active cycles -> one pulse
    @(negedge clk);
    x1 = '0; y1 = '0; x4 = '0; y4 = '0; clr = 1'b1;
    tick();
    @(negedge clk);
    clr = 1'b0;
    tick();
    tick();
    tick();
    rise_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      x1 = 1'b1;
      tick();
      rise_seen += int'(zr1);
    end
    chk("edge_rise_pulses", rise_seen, 1);
`ifdef OR_GATE_STATS_EN
    chk("edge_hi_cnt", int'(hi1), 5);
    chk("edge_rise_cnt", int'(rc1), 1);
`endif

    // Held high: no further pulses, hi_cnt saturates at 15
    rise_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rise_seen += int'(zr1);
    end
    chk("held_rise_pulses", rise_seen, 0);
`ifdef OR_GATE_STATS_EN
    chk("sat_hi_cnt", int'(hi1), 15);
    chk("sat_rise_cnt", int'(rc1), 1);
`endif

    // clr coincident with a qualifying rising sample
    @(negedge clk);
    x1 = '0;
    tick();
    @(negedge clk);
    x1 = 1'b1; clr = 1'b1;
    tick();
    chk("clr_rise_still_pulses", int'(zr1), 1);
`ifdef OR_GATE_STATS_EN
    chk("clr_hi_cnt", int'(hi1), 0);
    chk("clr_rise_cnt", int'(rc1), 0);
`endif
    @(negedge clk);
    clr = 1'b0;
    tick();

    // Asynchronous reset mid-cycle with x held high
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_z_q", int'(zq1), 0);
    chk("arst_rise", int'(zr1), 0);
    chk("arst_z", int'(z1), 1);
`ifdef OR_GATE_STATS_EN
    chk("arst_hi_cnt", int'(hi1), 0);
    chk("arst_rise_cnt", int'(rc1), 0);
`endif
    @(negedge clk);
    chk("arst_z_hold", int'(z1), 1);
    rst_n = 1'b1;
    tick();
    chk("arst_release_rise", int'(zr1), 1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      x1  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      y1  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      x4  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      y4  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      clr = ($urandom_range(0, 40) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
